// File: rtl/axi4_lite_ram_slave.sv
// axi4_lite_ram_slave: AXI4-Lite slave in front of a word-addressed on-chip RAM.
// Write and read channels are independent, and each can accept one transfer per cycle.
// Only the low IDX_W address bits select a word, so higher addresses alias onto the RAM.
// Every response is OKAY.
// Optional build macro: MEM_CLEAR_ON_RESET_EN. When it is defined, rst also zeroes the
// whole memory array. When it is not defined, the array has no reset and can be inferred as RAM.
module axi4_lite_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             wr_en;
  logic             rd_en;
  logic             unused_addr_bits;

  assign aw_idx = awaddr[IDX_W-1:0];
  assign ar_idx = araddr[IDX_W-1:0];
  assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:IDX_W], araddr[ADDR_WIDTH-1:IDX_W]};

  // Handshake readiness. Each channel can accept whenever its response slot is empty or is being drained.
  always_comb begin
    awready = !rst && (!bvalid || bready);
    wready  = awready;
    arready = !rst && (!rvalid || rready);
    wr_en   = awvalid && wvalid && awready;
    rd_en   = arvalid && arready;
    bresp   = 2'b00;
    rresp   = 2'b00;
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  // Memory array with a synchronous clear. Byte lanes are written according to wstrb.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (wstrb[b]) mem[aw_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
`else
  // Memory array with no reset, so it can map onto RAM. Byte lanes are written according to wstrb.
  // wr_en is already low while rst is high, because awready is held low during reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < STRB_W; b++)
        if (wstrb[b]) mem[aw_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
`endif

  // Write response flag. A new commit while the old response drains keeps bvalid high.
  always_ff @(posedge clk) begin
    if (rst)        bvalid <= 1'b0;
    else if (wr_en) bvalid <= 1'b1;
    else if (bready) bvalid <= 1'b0;
  end

  // Read data path with a latency of one cycle. rdata samples mem before any write in the
  // same cycle lands, so a read and a write to the same word return the old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_en) begin
      rvalid <= 1'b1;
      rdata  <= mem[ar_idx];
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Self-checking bench for axi4_lite_ram_slave.
// It runs directed scenarios, then randomized traffic checked against an array/queue model.
module tb_axi4_lite_ram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  axi4_lite_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  // Issue one write with bready=1 and wait a bounded time for the handshake. Update the model on success.
  task automatic write_word(input int unsigned idx, input logic [31:0] d, input logic [3:0] s,
                            output bit ok);
    awaddr = idx; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (awready && wready) ok = 1;
      next_cycle();
    end
    awvalid = 0; wvalid = 0;
    if (ok) ref_mem[idx % 256] = merge(ref_mem[idx % 256], d, s);
    next_cycle();
  endtask

  // Issue one read with rready=1. The data must appear exactly one cycle after the AR handshake.
  task automatic read_word(input int unsigned idx, output logic [31:0] d, output bit ok);
    bit got;
    araddr = idx; arvalid = 1; rready = 1; ok = 0; got = 0; d = 'x;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (arready) got = 1;
      next_cycle();
    end
    arvalid = 0;
    @(negedge clk);
    if (got && rvalid) begin ok = 1; d = rdata; end
    next_cycle();
  endtask

  task automatic test_reset;
    rst = 1; awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready: aw=%b w=%b ar=%b expected 0 0 0", awready, wready, arready);
      end
      if (c > 0) begin
        n_checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
          n_fail++;
          $display("FAIL reset_state: bvalid=%b rvalid=%b rdata=%h bresp=%b rresp=%b expected all 0",
                   bvalid, rvalid, rdata, bresp, rresp);
        end
      end
      next_cycle();
    end
    rst = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_handshake_ignored: bvalid=%b rvalid=%b expected 0 0", bvalid, rvalid);
    end
    next_cycle();
  endtask

`ifdef MEM_CLEAR_ON_RESET_EN
  task automatic test_mem_clear;
    logic [31:0] d; bit ok;
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = 32'h0;
      read_word(i, d, ok);
      n_checks++;
      if (!ok || d !== 32'h0 || rresp !== 2'b00) begin
        n_fail++; $display("FAIL mem_clear[%0d]: ok=%0d rdata=%h rresp=%b expected 00000000 00", i, ok, d, rresp);
      end
    end
  endtask
`endif

  task automatic test_back_to_back_write;
    logic [31:0] vals [3];
    logic [31:0] d; bit ok;
    vals[0] = 32'hAAAA_AAAA; vals[1] = 32'h5555_5555; vals[2] = 32'hF0F0_F0F0;
    bready = 1; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      awaddr = i + 1; wdata = vals[i]; awvalid = 1; wvalid = 1;
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b1 || wready !== 1'b1 || (i > 0 && bvalid !== 1'b1)) begin
        n_fail++; $display("FAIL b2b_write_stall[%0d]: aw=%b w=%b bvalid=%b expected 1 1 %0d",
                           i, awready, wready, bvalid, i > 0);
      end
      ref_mem[i + 1] = vals[i];
      next_cycle();
    end
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      n_fail++; $display("FAIL b2b_write_last_b: bvalid=%b bresp=%b expected 1 00", bvalid, bresp);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_write_b_drop: bvalid=%b expected 0", bvalid);
    end
    next_cycle();
    for (int i = 1; i <= 3; i++) begin
      read_word(i, d, ok);
      n_checks++;
      if (!ok || d !== ref_mem[i]) begin
        n_fail++; $display("FAIL b2b_write_readback[%0d]: ok=%0d got=%h expected %h", i, ok, d, ref_mem[i]);
      end
    end
  endtask

  task automatic test_strobe;
    logic [31:0] d; bit ok;
    write_word(1, 32'h1234_5678, 4'b0011, ok);
    read_word(1, d, ok);
    n_checks++;
    if (!ok || d !== 32'hAAAA_5678) begin
      n_fail++; $display("FAIL strobe: ok=%0d got=%h expected aaaa5678", ok, d);
    end
  endtask

  task automatic test_b_backpressure;
    logic [31:0] d; bit ok;
    bready = 0; awaddr = 1; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    n_checks++;
    if (awready !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_accept: awready=%b expected 1", awready);
    end
    ref_mem[1] = 32'h5555_5555;
    next_cycle();
    awaddr = 5; wdata = 32'h7777_7777;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: bvalid=%b aw=%b w=%b expected 1 0 0", c, bvalid, awready, wready);
      end
      next_cycle();
    end
    bready = 1;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1 || awready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: bvalid=%b awready=%b expected 1 1", bvalid, awready);
    end
    ref_mem[5] = 32'h7777_7777;
    next_cycle();
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++; $display("FAIL bp_chained_b: bvalid=%b expected 1", bvalid);
    end
    next_cycle();
    for (int i = 1; i <= 5; i += 4) begin
      read_word(i, d, ok);
      n_checks++;
      if (!ok || d !== ref_mem[i]) begin
        n_fail++; $display("FAIL bp_readback[%0d]: ok=%0d got=%h expected %h", i, ok, d, ref_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back_read;
    bit ok;
    write_word(0, $urandom, 4'hF, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_read_init: write handshake timed out, expected accept"); end
    rready = 1;
    for (int i = 0; i <= 4; i++) begin
      araddr = i; arvalid = (i < 4);
      @(negedge clk);
      n_checks++;
      if ((i < 4 && arready !== 1'b1) || (i > 0 && (rvalid !== 1'b1 || rdata !== ref_mem[i-1]))) begin
        n_fail++; $display("FAIL b2b_read[%0d]: arready=%b rvalid=%b rdata=%h expected 1 1 %h",
                           i, arready, rvalid, rdata, (i > 0) ? ref_mem[i-1] : 32'h0);
      end
      next_cycle();
    end
    arvalid = 0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_read_drop: rvalid=%b expected 0", rvalid);
    end
    next_cycle();
  endtask

  task automatic test_read_backpressure;
    rready = 0; araddr = 3; arvalid = 1;
    next_cycle();
    araddr = 2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== ref_mem[3]) begin
        n_fail++; $display("FAIL read_bp_hold[%0d]: rvalid=%b arready=%b rdata=%h expected 1 0 %h",
                           c, rvalid, arready, rdata, ref_mem[3]);
      end
      next_cycle();
    end
    rst = 1;
    next_cycle();
    rst = 0; arvalid = 0;
    @(negedge clk);
    n_checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL read_reset_discard: rvalid=%b rdata=%h expected 0 00000000", rvalid, rdata);
    end
    next_cycle();
  endtask

  task automatic test_random;
    logic [31:0] rq [$];
    int          pend_b;
    bit          ok, exp_aw, exp_ar;
    int unsigned widx, ridx;
    for (int i = 0; i < 16; i++) begin
      write_word(i, $urandom, 4'hF, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand_init[%0d]: write timed out, expected accept", i); end
    end
    pend_b = 0;
    for (int c = 0; c < 600; c++) begin
      widx = $urandom_range(0, 15); ridx = $urandom_range(0, 15);
      awaddr = ($urandom & 32'hFFFF_FF00) | widx;
      araddr = ($urandom & 32'hFFFF_FF00) | ridx;
      wdata = $urandom; wstrb = 4'($urandom);
      awvalid = ($urandom_range(0, 9) < 7); wvalid = ($urandom_range(0, 9) < 7);
      arvalid = ($urandom_range(0, 9) < 7);
      bready = ($urandom_range(0, 9) < 6); rready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_aw = (pend_b == 0) || bready;
      exp_ar = (rq.size() == 0) || rready;
      n_checks++;
      if (awready !== exp_aw || wready !== exp_aw || arready !== exp_ar) begin
        n_fail++; $display("FAIL rand_ready[%0d]: aw=%b w=%b ar=%b expected %b %b %b",
                           c, awready, wready, arready, exp_aw, exp_aw, exp_ar);
      end
      n_checks++;
      if (bvalid !== (pend_b > 0) || rvalid !== (rq.size() > 0)) begin
        n_fail++; $display("FAIL rand_valid[%0d]: bvalid=%b rvalid=%b expected %0d %0d",
                           c, bvalid, rvalid, pend_b > 0, rq.size() > 0);
      end
      if (rq.size() > 0) begin
        n_checks++;
        if (rdata !== rq[0]) begin
          n_fail++; $display("FAIL rand_rdata[%0d]: got=%h expected %h", c, rdata, rq[0]);
        end
        if (rready) void'(rq.pop_front());
      end
      if (pend_b > 0 && bready) pend_b--;
      if (arvalid && exp_ar) rq.push_back(ref_mem[ridx]);
      if (awvalid && wvalid && exp_aw) begin
        ref_mem[widx] = merge(ref_mem[widx], wdata, wstrb);
        pend_b++;
      end
      next_cycle();
    end
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    next_cycle();
    next_cycle();
  endtask

  initial begin
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    #1;
    test_reset();
`ifdef MEM_CLEAR_ON_RESET_EN
    test_mem_clear();
`endif
    test_back_to_back_write();
    test_strobe();
    test_b_backpressure();
    test_back_to_back_read();
    test_read_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
